pc_seq_ctrl: RTL and testbench

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

---
 rtl/pc_seq_pkg.sv | 7 +
 rtl/ras_stack.sv | 48 ++++
 rtl/pc_seq_ctrl.sv | 92 +++++++++
 tb/tb_pc_seq_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the program-counter sequencer.
// Holds the FSM state enum, the address width and the default interrupt vector.
package pc_seq_pkg;
  localparam int ADDR_W = 10;
  localparam logic [ADDR_W-1:0] INTR_VEC_DEF = 10'h3FF;
  typedef enum logic [1:0] {ST_INIT, ST_FETCH, ST_EXEC, ST_INTR} state_t;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with sticky overflow/underflow flag.
// Ports: CLK/RST (sync, active-high); push_i/din_i write; pop_i pops, dout_o is
// the current top (0 when empty); full_o/empty_o occupancy; err_o sticky error.
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W = ADDR_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         err_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q;
  logic [PW:0] cnt_q;
  logic err_q;
  assign full_o = cnt_q == (PW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign dout_o = empty_o ? '0 : mem_q[wp_q - 1'b1];
  assign err_o = err_q;
  // Write pointer always advances on push, so a push while full lands on the
  // oldest entry and the buffer behaves circularly.
  always_ff @(posedge CLK)
    if (push_i && !RST) mem_q[wp_q] <= din_i;
  always_ff @(posedge CLK) begin
    if (RST) begin
      wp_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (push_i) begin
      wp_q <= wp_q + 1'b1;
      cnt_q <= cnt_q + {{PW{1'b0}}, ~full_o};
      err_q <= err_q | full_o;
    end else if (pop_i) begin
      wp_q <= empty_o ? wp_q : wp_q - 1'b1;
      cnt_q <= cnt_q - {{PW{1'b0}}, ~empty_o};
      err_q <= err_q | empty_o;
    end
  end
endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: fetch/execute sequencer driving the program counter, with
// return-address stack and optional interrupt support (macro PC_SEQ_INTR_EN).
// Ports: CLK, RST (sync, active-high); PC_COUNT current PC; BR_ADDR target;
// IS_* / BR_TAKEN decoded instruction class; INTR level request;
// PC_LD/PC_INC/PC_DIN program-counter control; IR_LD instruction load;
// INT_ACK interrupt acknowledge; IE interrupt enable; STK_ERR sticky stack error.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] INTR_VEC = INTR_VEC_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PC_COUNT,
  input  logic [ADDR_W-1:0] BR_ADDR,
  input  logic              IS_BRANCH,
  input  logic              BR_TAKEN,
  input  logic              IS_CALL,
  input  logic              IS_RET,
  input  logic              IS_RETI,
  input  logic              IS_SEI,
  input  logic              IS_CLI,
  input  logic              INTR,
  output logic              PC_LD,
  output logic              PC_INC,
  output logic [ADDR_W-1:0] PC_DIN,
  output logic              IR_LD,
  output logic              INT_ACK,
  output logic              IE,
  output logic              STK_ERR
);
  state_t state_q, state_d;
  logic is_exec, is_intr, do_ret, do_call, do_br, push, pop, intr_go;
  logic [ADDR_W-1:0] stk_dout;
  logic stk_err, unused_full, unused_empty;
  always_ff @(posedge CLK) state_q <= RST ? ST_INIT : state_d;
  always_comb
    state_d = state_q == ST_INIT ? ST_FETCH :
              state_q == ST_FETCH ? ST_EXEC :
              (state_q == ST_EXEC && intr_go) ? ST_INTR : ST_FETCH;
  // RETI always pops like RET; RST gates every strobe so a reset cycle
  // neither pushes nor loads.
  always_comb begin
    is_exec = state_q == ST_EXEC;
    is_intr = state_q == ST_INTR;
    do_ret = is_exec & (IS_RET | IS_RETI);
    do_call = is_exec & ~IS_RET & ~IS_RETI & IS_CALL;
    do_br = is_exec & ~IS_RET & ~IS_RETI & ~IS_CALL & IS_BRANCH & BR_TAKEN;
    push = ~RST & (do_call | is_intr);
    pop = ~RST & do_ret;
    PC_LD = ~RST & (do_ret | do_call | do_br | is_intr);
    PC_INC = ~RST & (state_q == ST_FETCH);
    IR_LD = PC_INC;
    PC_DIN = !PC_LD ? '0 : do_ret ? stk_dout : is_intr ? INTR_VEC : BR_ADDR;
    STK_ERR = ~RST & stk_err;
  end
`ifdef PC_SEQ_INTR_EN
  logic ie_q, ie_d, pend_q, pend_d;
  always_ff @(posedge CLK) begin
    ie_q <= RST ? 1'b0 : ie_d;
    pend_q <= RST ? 1'b0 : pend_d;
  end
  // IE shows the value after this cycle's updates, so the EXEC exit test and
  // the visible flag agree; CLI wins if combined with SEI/RETI.
  always_comb begin
    ie_d = (is_intr | (is_exec & IS_CLI)) ? 1'b0 :
           (is_exec & (IS_SEI | IS_RETI)) ? 1'b1 : ie_q;
    pend_d = is_intr ? 1'b0 : pend_q | INTR;
  end
  assign intr_go = pend_q & ie_d;
  assign INT_ACK = ~RST & is_intr;
  assign IE = ~RST & ie_d;
`else
  logic unused_intr;
  assign unused_intr = ^{INTR, IS_SEI, IS_CLI};
  assign intr_go = 1'b0;
  assign INT_ACK = 1'b0;
  assign IE = 1'b0;
`endif
  ras_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_ras (
    .CLK(CLK),
    .RST(RST),
    .push_i(push),
    .pop_i(pop),
    .din_i(PC_COUNT),
    .dout_o(stk_dout),
    .full_o(unused_full),
    .empty_o(unused_empty),
    .err_o(stk_err)
  );
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed table, hand sequences and randomized model check.
module tb_pc_seq_ctrl;
  localparam int DEPTH = 8;
  localparam logic [9:0] VEC = 10'h3FF;
`ifdef PC_SEQ_INTR_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam logic [6:0] F_RETI = 7'b1000000, F_RET = 7'b0100000, F_CALL = 7'b0010000,
                         F_BR = 7'b0001000, F_TK = 7'b0000100, F_SEI = 7'b0000010,
                         F_CLI = 7'b0000001;
  localparam int P_INIT = 0, P_FETCH = 1, P_EXEC = 2, P_INTR = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] pc = '0, br = '0;
  logic is_branch = 0, br_taken = 0, is_call = 0, is_ret = 0, is_reti = 0, is_sei = 0, is_cli = 0, intr = 0;
  logic pc_ld, pc_inc, ir_ld, int_ack, ie, stk_err;
  logic [9:0] pc_din;
  logic [15:0] outs;
  int n_chk = 0, n_fail = 0;

  pc_seq_ctrl #(.STACK_DEPTH(DEPTH), .INTR_VEC(VEC)) dut (
    .CLK(clk), .RST(rst), .PC_COUNT(pc), .BR_ADDR(br),
    .IS_BRANCH(is_branch), .BR_TAKEN(br_taken), .IS_CALL(is_call), .IS_RET(is_ret),
    .IS_RETI(is_reti), .IS_SEI(is_sei), .IS_CLI(is_cli), .INTR(intr),
    .PC_LD(pc_ld), .PC_INC(pc_inc), .PC_DIN(pc_din), .IR_LD(ir_ld),
    .INT_ACK(int_ack), .IE(ie), .STK_ERR(stk_err)
  );

  always #5 clk = ~clk;
  assign outs = {pc_ld, pc_inc, ir_ld, int_ack, ie, stk_err, pc_din};

  typedef struct {
    logic rst;
    logic [6:0] fl;
    logic [9:0] pc, br;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [15:0] E(input logic ld, inc, ir, ack, ie_v, err, input logic [9:0] d);
    return {ld, inc, ir, ack, ie_v, err, d};
  endfunction
  function automatic vec_t V(input logic r, input logic [6:0] f, input logic [9:0] p, b, input logic [15:0] e);
    vec_t v;
    v.rst = r; v.fl = f; v.pc = p; v.br = b; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got {ld,inc,ir,ack,ie,err,din}=%h expected %h", nm, a, e);
    end
  endtask

  task automatic step(input logic r, input logic [6:0] f, input logic i, input logic [9:0] p, b, output logic [15:0] a);
    @(negedge clk);
    rst = r; {is_reti, is_ret, is_call, is_branch, br_taken, is_sei, is_cli} = f;
    intr = i; pc = p; br = b;
    #1 a = outs;
  endtask

  task automatic ck(input string nm, input logic r, input logic [6:0] f, input logic i, input logic [9:0] p, b, input logic [15:0] e);
    logic [15:0] a;
    step(r, f, i, p, b, a);
    chk(nm, a, e);
  endtask

  task automatic rs();
    ck("rst", 1, 0, 0, 0, 0, 16'h0);
    ck("init", 0, 0, 0, 0, 0, 16'h0);
  endtask

  // Behavioural reference: stack as a queue of return addresses.
  int m_ph;
  bit m_ie, m_pend, m_err;
  logic [9:0] m_q[$];

  task automatic mpush(input logic [9:0] v);
    m_q.push_back(v);
    if (m_q.size() > DEPTH) begin
      void'(m_q.pop_front());
      m_err = 1;
    end
  endtask

  task automatic mstep(input logic r, input logic [6:0] f, input logic i, input logic [9:0] p, b, output logic [15:0] e);
    logic ld, inc, ack;
    logic [9:0] d;
    bit nie, err0;
    int nph;
    ld = 0; inc = 0; ack = 0; d = '0; nie = m_ie; err0 = m_err; nph = m_ph;
    if (r) begin
      e = '0; m_ph = P_INIT; m_ie = 0; m_pend = 0; m_err = 0; m_q.delete();
      return;
    end
    case (m_ph)
      P_INIT: nph = P_FETCH;
      P_FETCH: begin inc = 1; nph = P_EXEC; end
      P_EXEC: begin
        if (f[6] | f[5]) begin
          ld = 1;
          if (m_q.size() == 0) m_err = 1;
          else d = m_q.pop_back();
          if (EN && f[6]) nie = 1;
        end else if (f[4]) begin
          ld = 1; d = b; mpush(p);
        end else if (f[3] & f[2]) begin
          ld = 1; d = b;
        end
        if (EN && f[1]) nie = 1;
        if (EN && f[0]) nie = 0;
        nph = (EN && m_pend && nie) ? P_INTR : P_FETCH;
      end
      default: begin
        ld = 1; d = VEC; ack = 1; nie = 0; mpush(p); nph = P_FETCH;
      end
    endcase
    e = {ld, inc, inc, ack, nie, err0, d};
    if (EN) m_pend = (m_ph == P_INTR) ? 1'b0 : (m_pend | i);
    m_ie = nie;
    m_ph = nph;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, e;
    logic [6:0] f;
    // Directed table from reset: NOP, call/ret, branches, priority, empty pop, reset discard.
    tbl.push_back(V(1, 0, 0, 0, 16'h0));
    tbl.push_back(V(0, 0, 0, 0, 16'h0));
    tbl.push_back(V(0, 0, 0, 0, E(0,1,1,0,0,0,0)));
    tbl.push_back(V(0, 0, 0, 0, 16'h0));
    tbl.push_back(V(0, 0, 0, 0, E(0,1,1,0,0,0,0)));
    tbl.push_back(V(0, F_CALL, 10'h011, 10'h040, E(1,0,0,0,0,0,10'h040)));
    tbl.push_back(V(0, 0, 0, 0, E(0,1,1,0,0,0,0)));
    tbl.push_back(V(0, F_BR|F_TK, 0, 10'h155, E(1,0,0,0,0,0,10'h155)));
    tbl.push_back(V(0, 0, 0, 0, E(0,1,1,0,0,0,0)));
    tbl.push_back(V(0, F_BR, 0, 10'h2AA, 16'h0));
    tbl.push_back(V(0, 0, 0, 0, E(0,1,1,0,0,0,0)));
    tbl.push_back(V(0, F_RET, 0, 0, E(1,0,0,0,0,0,10'h011)));
    tbl.push_back(V(0, 0, 0, 0, E(0,1,1,0,0,0,0)));
    tbl.push_back(V(0, F_CALL|F_RET, 10'h077, 10'h123, E(1,0,0,0,0,0,10'h000)));
    tbl.push_back(V(0, 0, 0, 0, E(0,1,1,0,0,1,0)));
    tbl.push_back(V(0, F_CALL, 10'h3FF, 10'h3FF, E(1,0,0,0,0,1,10'h3FF)));
    tbl.push_back(V(0, 0, 0, 0, E(0,1,1,0,0,1,0)));
    tbl.push_back(V(0, F_RET, 0, 0, E(1,0,0,0,0,1,10'h3FF)));
    tbl.push_back(V(0, 0, 0, 0, E(0,1,1,0,0,1,0)));
    tbl.push_back(V(0, F_RET, 0, 0, E(1,0,0,0,0,1,10'h000)));
    tbl.push_back(V(0, 0, 0, 0, E(0,1,1,0,0,1,0)));
    tbl.push_back(V(1, F_CALL, 10'h055, 10'h066, 16'h0));
    tbl.push_back(V(0, 0, 0, 0, 16'h0));
    tbl.push_back(V(0, 0, 0, 0, E(0,1,1,0,0,0,0)));
    tbl.push_back(V(0, F_RET, 0, 0, E(1,0,0,0,0,0,10'h000)));
    tbl.push_back(V(0, 0, 0, 0, E(0,1,1,0,0,1,0)));
    foreach (tbl[i]) ck($sformatf("vec%0d", i), tbl[i].rst, tbl[i].fl, 1'b0, tbl[i].pc, tbl[i].br, tbl[i].exp);

    // Nine nested calls into an eight-deep stack, then unwind.
    rs();
    for (int k = 0; k < 9; k++) begin
      ck("nest_fetch", 0, 0, 0, 0, 0, E(0,1,1,0,0,0,0));
      ck("nest_call", 0, F_CALL, 0, 10'(256 + k), 10'(512 + k), E(1,0,0,0,0,0,10'(512 + k)));
    end
    ck("nest_err", 0, 0, 0, 0, 0, E(0,1,1,0,0,1,0));
    for (int k = 8; k >= 1; k--) begin
      ck("nest_ret", 0, F_RET, 0, 0, 0, E(1,0,0,0,0,1,10'(256 + k)));
      ck("nest_fetch2", 0, 0, 0, 0, 0, E(0,1,1,0,0,1,0));
    end
    ck("nest_empty", 0, F_RET, 0, 0, 0, E(1,0,0,0,0,1,10'h000));

`ifdef PC_SEQ_INTR_EN
    rs();
    ck("i_f0", 0, 0, 0, 0, 0, E(0,1,1,0,0,0,0));
    ck("i_sei", 0, F_SEI, 0, 0, 0, E(0,0,0,0,1,0,0));
    ck("i_f1", 0, 0, 1, 10'h020, 0, E(0,1,1,0,1,0,0));
    ck("i_ex", 0, 0, 0, 10'h020, 0, E(0,0,0,0,1,0,0));
    ck("i_ack", 0, 0, 0, 10'h020, 0, E(1,0,0,1,0,0,10'h3FF));
    ck("i_f2", 0, 0, 0, 0, 0, E(0,1,1,0,0,0,0));
    ck("i_reti", 0, F_RETI, 0, 0, 0, E(1,0,0,0,1,0,10'h020));
    ck("i_f3", 0, 0, 0, 0, 0, E(0,1,1,0,1,0,0));
    ck("i_ex3", 0, 0, 0, 0, 0, E(0,0,0,0,1,0,0));
    ck("i_f4", 0, 0, 1, 0, 0, E(0,1,1,0,1,0,0));
    ck("i_ex4", 0, 0, 0, 0, 0, E(0,0,0,0,1,0,0));
    ck("i_rst", 1, 0, 0, 10'h0AA, 0, 16'h0);
    ck("i_init", 0, 0, 0, 0, 0, 16'h0);
    ck("i_f5", 0, 0, 0, 0, 0, E(0,1,1,0,0,0,0));
    ck("i_noret", 0, F_RET, 0, 0, 0, E(1,0,0,0,0,0,10'h000));
`else
    rs();
    ck("d_f0", 0, 0, 1, 0, 0, E(0,1,1,0,0,0,0));
    ck("d_sei", 0, F_SEI, 1, 0, 0, 16'h0);
    ck("d_f1", 0, 0, 1, 0, 0, E(0,1,1,0,0,0,0));
    ck("d_call", 0, F_CALL, 0, 10'h033, 10'h044, E(1,0,0,0,0,0,10'h044));
    ck("d_f2", 0, 0, 0, 0, 0, E(0,1,1,0,0,0,0));
    ck("d_reti", 0, F_RETI, 1, 0, 0, E(1,0,0,0,0,0,10'h033));
    ck("d_f3", 0, 0, 0, 0, 0, E(0,1,1,0,0,0,0));
`endif

    // Randomized run against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic r, i;
      logic [9:0] p, b;
      r = (n == 0) || ($urandom_range(0, 63) == 0);
      f = 7'($urandom);
      if (f[0]) begin f[6] = 0; f[1] = 0; end
      i = $urandom_range(0, 7) == 0;
      p = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
      b = 10'($urandom);
      step(r, f, i, p, b, a);
      mstep(r, f, i, p, b, e);
      chk("rand", a, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
